// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1-write/1-read inferred SRAM.
// Collision policies, sweep FSM states and the byte-lane count helper.
package sram_pkg;

    typedef enum logic [1:0] {
        WM_READ_FIRST  = 2'd0,
        WM_WRITE_FIRST = 2'd1,
        WM_UNDEF       = 2'd2
    } write_mode_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read return pipeline: LATENCY register stages carrying data, valid and err.
// Data stages only load on a valid beat, so the output holds between strobes.
module sram_rd_pipe #(
    parameter int WIDTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic             in_err,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_err,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [WIDTH-1:0]   dat_q [LATENCY];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            err_q[0] <= in_valid & in_err;
            if (in_valid) begin
                dat_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/sram_1w1r_param.sv
// Parametrised 1-write/1-read synchronous SRAM with byte enables, collision
// policy, post-reset zero-fill sweep and a configurable read pipeline.
module sram_1w1r_param
    import sram_pkg::*;
#(
    parameter int          DATA_WIDTH   = 128,
    parameter int          DEPTH        = 257,
    parameter int          READ_LATENCY = 1,
    parameter write_mode_e WRITE_MODE   = WM_UNDEF,
    parameter bit          ZERO_INIT    = 1'b1,
    parameter int          ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_b,
    output logic                    init_done,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]   a_data_in,
    input  logic                    b_re,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_data_out,
    output logic                    b_valid,
    output logic                    b_err,
    output init_state_e             state_dbg
);

    localparam int                    NB        = byte_count(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_V   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  a_in_range, b_in_range;
    logic                  wr_en, rd_en, collide;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data, rd_word, rd_data;

    assign a_in_range = {1'b0, a_addr} < DEPTH_V;
    assign b_in_range = {1'b0, b_addr} < DEPTH_V;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            if (ZERO_INIT) state_q <= INIT;
            else           state_q <= READY;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep owns the write port while in INIT; both user ports are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = a_addr;
        wr_be   = a_be;
        wr_data = a_data_in;
        rd_en   = 1'b0;
        case (state_q)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_be   = '1;
                wr_data = '0;
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                wr_en = a_we & a_in_range & (|a_be);
                rd_en = b_re;
            end
            default: state_d = INIT;
        endcase
    end

    assign init_done = (state_q == READY);
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // wr_en already implies an in-range write address, so a match means b is in range too.
    assign collide = wr_en & rd_en & (a_addr == b_addr);
    assign rd_word = b_in_range ? mem[b_addr] : '0;

    always_comb begin
        rd_data = rd_word;
        if (WRITE_MODE == WM_WRITE_FIRST && collide) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_data[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // b_valid is a one-cycle strobe per accepted read; there is no backpressure,
    // so every b_re in READY yields exactly one strobe READ_LATENCY edges later.
    sram_rd_pipe #(
        .WIDTH   (DATA_WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (rd_en),
        .in_err    (~b_in_range),
        .in_data   (rd_data),
        .out_valid (b_valid),
        .out_err   (b_err),
        .out_data  (b_data_out)
    );

endmodule

// File: tb/tb_sram_1w1r_param.sv
// Directed bench for sram_1w1r_param: three instances (UNDEF/L1, READ_FIRST/L2,
// WRITE_FIRST/L1) share stimulus; inputs change and outputs are sampled on negedge.
module tb_sram_1w1r_param;
    import sram_pkg::*;

    localparam int DW    = 128;
    localparam int DEPTH = 257;
    localparam int AW    = 9;
    localparam int NB    = 16;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [NB-1:0] a_be;
    logic [DW-1:0] a_data_in;
    logic          b_re;
    logic [AW-1:0] b_addr;

    logic          done_u, done_r, done_w;
    logic [DW-1:0] dout_u, dout_r, dout_w;
    logic          vld_u, vld_r, vld_w;
    logic          err_u, err_r, err_w;
    init_state_e   st_u, st_r, st_w;

    int total = 0;
    int fails = 0;

    sram_1w1r_param #(.READ_LATENCY(1), .WRITE_MODE(WM_UNDEF)) u_undef (
        .clk(clk), .rst_b(rst_b), .init_done(done_u),
        .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_data_in(a_data_in),
        .b_re(b_re), .b_addr(b_addr), .b_data_out(dout_u), .b_valid(vld_u),
        .b_err(err_u), .state_dbg(st_u)
    );

    sram_1w1r_param #(.READ_LATENCY(2), .WRITE_MODE(WM_READ_FIRST)) u_rf (
        .clk(clk), .rst_b(rst_b), .init_done(done_r),
        .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_data_in(a_data_in),
        .b_re(b_re), .b_addr(b_addr), .b_data_out(dout_r), .b_valid(vld_r),
        .b_err(err_r), .state_dbg(st_r)
    );

    sram_1w1r_param #(.READ_LATENCY(1), .WRITE_MODE(WM_WRITE_FIRST)) u_wf (
        .clk(clk), .rst_b(rst_b), .init_done(done_w),
        .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_data_in(a_data_in),
        .b_re(b_re), .b_addr(b_addr), .b_data_out(dout_w), .b_valid(vld_w),
        .b_err(err_w), .state_dbg(st_w)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [NB-1:0] be, input logic [DW-1:0] data);
        a_we      = 1'b1;
        a_addr    = addr;
        a_be      = be;
        a_data_in = data;
        @(negedge clk);
        a_we      = 1'b0;
        a_be      = '0;
    endtask

    // Single read: L1 instances strobe one negedge later, the L2 instance one after that.
    task automatic rd_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                          input logic err);
        b_re   = 1'b1;
        b_addr = addr;
        @(negedge clk);
        b_re   = 1'b0;
        check({tag, "_u_vld"}, DW'(vld_u), DW'(1));
        check({tag, "_u_dat"}, dout_u, exp);
        check({tag, "_u_err"}, DW'(err_u), DW'(err));
        check({tag, "_w_vld"}, DW'(vld_w), DW'(1));
        check({tag, "_w_dat"}, dout_w, exp);
        check({tag, "_w_err"}, DW'(err_w), DW'(err));
        check({tag, "_r_early"}, DW'(vld_r), DW'(0));
        @(negedge clk);
        check({tag, "_r_vld"}, DW'(vld_r), DW'(1));
        check({tag, "_r_dat"}, dout_r, exp);
        check({tag, "_r_err"}, DW'(err_r), DW'(err));
        check({tag, "_u_once"}, DW'(vld_u), DW'(0));
        check({tag, "_u_hold"}, dout_u, exp);
    endtask

    task automatic sweep_count(output int n, output logic saw);
        n   = 0;
        saw = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (vld_u | vld_r | vld_w) saw = 1'b1;
        end while (!(done_u & done_r & done_w) && n < 400);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic saw;

        a_we = 1'b0; a_addr = '0; a_be = '0; a_data_in = '0;
        b_re = 1'b0; b_addr = '0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_done",  DW'({done_u, done_r, done_w}), DW'(0));
        check("rst_valid", DW'({vld_u, vld_r, vld_w}), DW'(0));
        check("rst_err",   DW'({err_u, err_r, err_w}), DW'(0));
        check("rst_dout_u", dout_u, '0);
        check("rst_dout_r", dout_r, '0);
        check("rst_state", DW'(st_u), DW'(INIT));

        // Reads during the sweep must be ignored.
        rst_b  = 1'b1;
        b_re   = 1'b1;
        b_addr = '0;
        sweep_count(n, saw);
        b_re   = 1'b0;
        check("sweep_len", DW'(n), DW'(257));
        check("sweep_no_valid", DW'(saw), DW'(0));
        check("ready_state", DW'(st_r), DW'(READY));

        rd_chk("zero0",   9'd0,   '0, 1'b0);
        rd_chk("zero128", 9'd128, '0, 1'b0);
        rd_chk("zero256", 9'd256, '0, 1'b0);

        wr(9'd5, '1, {16{8'hA5}});
        rd_chk("wr5", 9'd5, {16{8'hA5}}, 1'b0);

        wr(9'd5, '1, {16{8'h11}});
        wr(9'd5, 16'h0001, {16{8'hFF}});
        rd_chk("be0", 9'd5, {{15{8'h11}}, 8'hFF}, 1'b0);

        wr(9'd5, 16'h0000, {16{8'h77}});
        rd_chk("be_none", 9'd5, {{15{8'h11}}, 8'hFF}, 1'b0);

        // Same-edge write and read at addr 7, which still holds the swept zero.
        a_we = 1'b1; a_addr = 9'd7; a_be = '1; a_data_in = {16{8'hCC}};
        b_re = 1'b1; b_addr = 9'd7;
        @(negedge clk);
        a_we = 1'b0; a_be = '0; b_re = 1'b0;
        check("col_wf_dat", dout_w, {16{8'hCC}});
        check("col_wf_vld", DW'(vld_w), DW'(1));
        check("col_u_vld",  DW'(vld_u), DW'(1));
        check("col_u_err",  DW'(err_u), DW'(0));
        @(negedge clk);
        check("col_rf_vld", DW'(vld_r), DW'(1));
        check("col_rf_dat", dout_r, '0);
        check("col_rf_err", DW'(err_r), DW'(0));
        rd_chk("after_col", 9'd7, {16{8'hCC}}, 1'b0);

        // Back-to-back reads give back-to-back strobes.
        b_re = 1'b1; b_addr = 9'd5;
        @(negedge clk);
        b_addr = 9'd7;
        check("b2b_u_vld0", DW'(vld_u), DW'(1));
        check("b2b_u_dat0", dout_u, {{15{8'h11}}, 8'hFF});
        @(negedge clk);
        b_re = 1'b0;
        check("b2b_u_vld1", DW'(vld_u), DW'(1));
        check("b2b_u_dat1", dout_u, {16{8'hCC}});
        check("b2b_r_vld0", DW'(vld_r), DW'(1));
        check("b2b_r_dat0", dout_r, {{15{8'h11}}, 8'hFF});
        @(negedge clk);
        check("b2b_r_vld1", DW'(vld_r), DW'(1));
        check("b2b_r_dat1", dout_r, {16{8'hCC}});
        check("b2b_u_end",  DW'(vld_u), DW'(0));

        // Out-of-range write is a no-op; out-of-range read returns zero with err.
        wr(9'd300, '1, {16{8'hDE}});
        rd_chk("oor300", 9'd300, '0, 1'b1);
        rd_chk("alias44", 9'd44, '0, 1'b0);
        rd_chk("keep5", 9'd5, {{15{8'h11}}, 8'hFF}, 1'b0);

        // Reset with a read in flight in the L2 pipe and another being driven.
        b_re = 1'b1; b_addr = 9'd5;
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        b_re = 1'b0;
        check("rst_fl_valid", DW'({vld_u, vld_r, vld_w}), DW'(0));
        check("rst_fl_dout",  dout_u, '0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (vld_u | vld_r | vld_w) saw = 1'b1;
        end
        check("rst_fl_quiet", DW'(saw), DW'(0));

        // Reset again at sweep cycle 100; the sweep must restart from scratch.
        rst_b = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_sweep_busy", DW'({done_u, done_r, done_w}), DW'(0));
        rst_b = 1'b0;
        @(negedge clk);
        check("mid_rst_state", DW'(st_w), DW'(INIT));
        rst_b = 1'b1;
        sweep_count(n, saw);
        check("resweep_len", DW'(n), DW'(257));
        check("resweep_no_valid", DW'(saw), DW'(0));
        rd_chk("rezero5", 9'd5, '0, 1'b0);
        rd_chk("rezero7", 9'd7, '0, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/sram_1w1r_param.md
# sram_1w1r_param

Parametrised one-write/one-read synchronous SRAM, successor to the fixed-size single-port 1rw macros. Adds independent write and read ports, byte-enable writes, a selectable read-during-write collision policy, a configurable read pipeline with a valid strobe, and a post-reset zero-fill sweep. Sits behind TSSV-generated datapath blocks as a generic storage primitive; it is an inferred-RAM model, not a vendor wrapper.

## Interface
- DATA_WIDTH, 128, word width in bits; must be a multiple of 8
- DEPTH, 257, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width (derived, not overridden)
- READ_LATENCY, 1, cycles from read issue to data; legal values 1 or 2
- WRITE_MODE, WM_UNDEF, same-address collision policy: WM_READ_FIRST, WM_WRITE_FIRST, WM_UNDEF
- ZERO_INIT, 1, 1 = run the zero-fill sweep after reset; 0 = ready immediately
- clk  input  1  clock, all state on rising edge
- rst_b  input  1  asynchronous active-low reset
- init_done  output  1  high once the array is usable
- a_we  input  1  write enable
- a_addr  input  ADDR_WIDTH  write address
- a_be  input  DATA_WIDTH/8  byte enables, bit i gates a_data_in[8i+7:8i]
- a_data_in  input  DATA_WIDTH  write data
- b_re  input  1  read enable
- b_addr  input  ADDR_WIDTH  read address
- b_data_out  output  DATA_WIDTH  read data
- b_valid  output  1  one-cycle strobe qualifying b_data_out
- b_err  output  1  aligned with b_valid; read address was >= DEPTH

## Operation
- FSM states INIT, READY. Reset enters INIT if ZERO_INIT=1, else READY.
- INIT: internal counter 0..DEPTH-1 writes all-zero words, one per cycle; a_we and b_re ignored; init_done=0. After writing DEPTH-1, next state READY.
- READY: init_done=1; port accesses accepted every cycle, no backpressure.
- Write: a_we=1 with a_addr < DEPTH updates only bytes with a_be set; a_addr >= DEPTH or a_be=0 is a no-op.
- Read: b_re=1 launches a read; b_addr >= DEPTH returns zero with b_err=1.
- Collision (a_we & b_re & a_addr==b_addr, in range): WM_READ_FIRST returns pre-write word; WM_WRITE_FIRST returns pre-write word with enabled bytes replaced by a_data_in; WM_UNDEF returns an unspecified value (bench must not check data, b_valid still asserted, b_err=0).
- Memory array is not reset; only control/pipeline state is.

## Timing
- Reset values: init_done=0 (1 if ZERO_INIT=0), b_valid=0, b_err=0, b_data_out=0, sweep counter=0.
- Reset asserted mid-sweep or mid-read: sweep restarts from 0 after release; in-flight reads discarded, no b_valid.
- Sweep length exactly DEPTH cycles; init_done rises on the edge after the last zero write.
- Read issued at edge t: b_data_out/b_valid/b_err updated at edge t+READ_LATENCY; back-to-back reads give back-to-back strobes.
- b_data_out holds its last value when b_valid=0.
- Write at edge t is visible to a read issued at edge t+1 in all modes.

## Structure
- Package sram_pkg: write_mode_e enum, init_state_e enum {INIT, READY}, helper constant for byte count.
- Sub-module sram_rd_pipe: READ_LATENCY-deep register stage carrying data, valid, err; top holds array, FSM, collision mux.

## Test plan
- ZERO_INIT=1, DEPTH=257: release reset, count cycles -> init_done after 257; read addrs 0, 128, 256 -> 0, b_err=0.
- Write 0xA5..A5 to addr 5, a_be all ones; next cycle read 5 -> data after READ_LATENCY with single b_valid.
- Addr 5 holds 0x11..11; write 0xFF..FF with a_be=0x0001 -> readback shows only byte 0 = 0xFF.
- Same-cycle write/read addr 7, old 0x0, new 0xCC..CC: READ_FIRST -> 0x0; WRITE_FIRST -> 0xCC..CC; UNDEF -> b_valid only.
- Read addr 300, write addr 300 -> b_data_out=0, b_err=1, no array word modified.
- Assert rst_b at sweep cycle 100 and with two reads in flight -> no b_valid, sweep restarts, init_done after 257 further cycles.
